// File: rtl/decomp_pkg.sv
// Shared types and constants for the decompression-path byte controllers.
package decomp_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned KEY_W  = 8;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } ctrl_state_e;

endpackage

// File: rtl/decrypt.sv
// Byte-wide decrypt core: purely combinational, out = ~(data ^ key).
module decrypt
    import decomp_pkg::*;
(
    input  logic [BYTE_W-1:0] data_i,
    input  logic [KEY_W-1:0]  key_i,
    output logic [BYTE_W-1:0] data_o
);

    assign data_o = ~(data_i ^ key_i);

endmodule

// File: rtl/decrypt_stream_ctrl.sv
// Frame controller: streams a fixed number of encrypted bytes through the
// decrypt core with valid/ready on both sides, marks the last byte and
// reports completion.
module decrypt_stream_ctrl
    import decomp_pkg::*;
#(
    parameter int unsigned LEN_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              key_load_i,
    input  logic [KEY_W-1:0]  key_in_i,
    input  logic              start_i,
    input  logic [LEN_W-1:0]  frame_len_i,
    input  logic              abort_i,
    input  logic              in_valid_i,
    input  logic [BYTE_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic              out_valid_o,
    output logic [BYTE_W-1:0] out_data_o,
    output logic              out_last_o,
    input  logic              out_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    ctrl_state_e       state_q;
    logic [KEY_W-1:0]  key_q;
    logic              key_vld_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt_q;
    logic              out_valid_q;
    logic [BYTE_W-1:0] out_data_q;
    logic              out_last_q;
    logic              done_q;
    logic              err_q;

    logic [BYTE_W-1:0] dec_data;
    logic              accept;
    logic              is_last;

    decrypt u_decrypt (
        .data_i (in_data_i),
        .key_i  (key_q),
        .data_o (dec_data)
    );

    // Input side is ready in RUN whenever the output register is free or draining.
    always_comb begin
        in_ready_o = (state_q == StRun) && (!out_valid_q || out_ready_i);
        accept     = in_ready_o && in_valid_i;
        is_last    = (cnt_q == len_q - LEN_W'(1));
    end

    // FSM, key/length/counter registers and the output register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            key_q       <= '0;
            key_vld_q   <= 1'b0;
            len_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (abort_i) begin
                // Key state survives an abort; only the frame is dropped.
                state_q     <= StIdle;
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
                cnt_q       <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (key_load_i) begin
                            key_q     <= key_in_i;
                            key_vld_q <= 1'b1;
                        end
                        if (start_i) begin
                            // A key loaded in this same cycle counts as present.
                            if (!(key_vld_q || key_load_i)) begin
                                err_q <= 1'b1;
                            end else if (frame_len_i == '0) begin
                                done_q <= 1'b1;
                            end else begin
                                len_q   <= frame_len_i;
                                cnt_q   <= '0;
                                state_q <= StRun;
                            end
                        end
                    end
                    StRun: begin
                        if (accept) begin
                            out_data_q  <= dec_data;
                            out_valid_q <= 1'b1;
                            out_last_q  <= is_last;
                            cnt_q       <= cnt_q + LEN_W'(1);
                            if (is_last) begin
                                state_q <= StDrain;
                            end
                        end else if (out_ready_i) begin
                            out_valid_q <= 1'b0;
                        end
                    end
                    StDrain: begin
                        if (out_valid_q && out_ready_i) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;
    assign busy_o      = (state_q != StIdle);
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_decrypt_stream_ctrl.sv
// Directed self-checking bench for decrypt_stream_ctrl.
module tb_decrypt_stream_ctrl;

    localparam int LEN_W = 16;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             key_load_i;
    logic [7:0]       key_in_i;
    logic             start_i;
    logic [LEN_W-1:0] frame_len_i;
    logic             abort_i;
    logic             in_valid_i;
    logic [7:0]       in_data_i;
    logic             in_ready_o;
    logic             out_valid_o;
    logic [7:0]       out_data_o;
    logic             out_last_o;
    logic             out_ready_i;
    logic             busy_o;
    logic             done_o;
    logic             err_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    decrypt_stream_ctrl #(.LEN_W(LEN_W)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .key_load_i  (key_load_i),
        .key_in_i    (key_in_i),
        .start_i     (start_i),
        .frame_len_i (frame_len_i),
        .abort_i     (abort_i),
        .in_valid_i  (in_valid_i),
        .in_data_i   (in_data_i),
        .in_ready_o  (in_ready_o),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_last_o  (out_last_o),
        .out_ready_i (out_ready_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    function automatic logic [7:0] gen_byte(input int idx);
        case (idx)
            0:       return 8'h00;
            1:       return 8'hFF;
            2:       return 8'hA5;
            3:       return 8'h5A;
            default: return 8'(idx * 37) ^ 8'h3C;
        endcase
    endfunction

    task automatic load_key(input logic [7:0] k);
        key_load_i = 1'b1;
        key_in_i   = k;
        tick();
        key_load_i = 1'b0;
    endtask

    task automatic start_frame(input logic [LEN_W-1:0] len);
        start_i     = 1'b1;
        frame_len_i = len;
        tick();
        start_i = 1'b0;
    endtask

    // Streams n bytes; mode 0 = always ready, 1 = ready pattern 1,0,0,1, 2 = random stalls.
    // kl_cycle >= 0 pulses key_load (0x33) at that loop cycle.
    task automatic stream_frame(input logic [7:0] key, input int n, input int mode,
                                input int kl_cycle, output int cycles);
        int         i = 0;
        int         o = 0;
        int         cyc = 0;
        int         bound;
        logic       exp_ir;
        logic       prev_stall = 1'b0;
        logic [7:0] prev_data = 8'h00;
        logic       prev_last = 1'b0;
        logic [7:0] exp_data;
        bound = 4 * n + 50;
        while (o < n && cyc < bound) begin
            in_valid_i = (i < n);
            in_data_i  = gen_byte(i);
            case (mode)
                0:       out_ready_i = 1'b1;
                1:       out_ready_i = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: out_ready_i = ($urandom_range(0, 15) != 0);
            endcase
            key_load_i = (cyc == kl_cycle);
            key_in_i   = 8'h33;
            #1;
            checks++;
            if (busy_o !== 1'b1 || done_o !== 1'b0) begin
                failures++;
                $display("FAIL stream_busy_done cyc=%0d busy=%b done=%b required busy=1 done=0",
                         cyc, busy_o, done_o);
            end
            exp_ir = (i < n) && (!out_valid_o || out_ready_i);
            checks++;
            if (in_ready_o !== exp_ir) begin
                failures++;
                $display("FAIL stream_in_ready cyc=%0d got=%b required=%b", cyc, in_ready_o, exp_ir);
            end
            if (prev_stall) begin
                checks++;
                if (out_valid_o !== 1'b1 || out_data_o !== prev_data || out_last_o !== prev_last)
                begin
                    failures++;
                    $display("FAIL stream_hold cyc=%0d got v=%b d=%h l=%b required v=1 d=%h l=%b",
                             cyc, out_valid_o, out_data_o, out_last_o, prev_data, prev_last);
                end
            end
            if (out_valid_o === 1'b1 && out_ready_i) begin
                exp_data = ~(gen_byte(o) ^ key);
                checks++;
                if (out_data_o !== exp_data || out_last_o !== (o == n - 1)) begin
                    failures++;
                    $display("FAIL stream_out idx=%0d got d=%h l=%b required d=%h l=%b",
                             o, out_data_o, out_last_o, exp_data, (o == n - 1));
                end
                o++;
            end
            prev_stall = (out_valid_o === 1'b1) && !out_ready_i;
            prev_data  = out_data_o;
            prev_last  = out_last_o;
            if (in_valid_i && in_ready_o === 1'b1) i++;
            tick();
            cyc++;
        end
        in_valid_i  = 1'b0;
        key_load_i  = 1'b0;
        out_ready_i = 1'b0;
        cycles      = cyc;
        checks++;
        if (o != n) begin
            failures++;
            $display("FAIL stream_timeout outputs=%0d required=%0d", o, n);
        end
        checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || out_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL stream_done got done=%b busy=%b ov=%b required done=1 busy=0 ov=0",
                     done_o, busy_o, out_valid_o);
        end
        tick();
        checks++;
        if (done_o !== 1'b0) begin
            failures++;
            $display("FAIL stream_done_pulse got done=%b required 0", done_o);
        end
    endtask

    task automatic test_reset();
        rst_ni      = 1'b0;
        key_load_i  = 1'b0;
        key_in_i    = 8'h00;
        start_i     = 1'b0;
        frame_len_i = '0;
        abort_i     = 1'b0;
        in_valid_i  = 1'b0;
        in_data_i   = 8'h00;
        out_ready_i = 1'b1;
        repeat (3) tick();
        rst_ni = 1'b1;
        tick();
        checks++;
        if (in_ready_o !== 1'b0 || out_valid_o !== 1'b0 || out_data_o !== 8'h00 ||
            out_last_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_state ir=%b ov=%b od=%h ol=%b busy=%b done=%b err=%b required all 0",
                     in_ready_o, out_valid_o, out_data_o, out_last_o, busy_o, done_o, err_o);
        end
    endtask

    task automatic test_err_no_key();
        start_frame(16'd5);
        checks++;
        if (err_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0) begin
            failures++;
            $display("FAIL err_no_key got err=%b busy=%b done=%b required err=1 busy=0 done=0",
                     err_o, busy_o, done_o);
        end
        tick();
        checks++;
        if (err_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL err_pulse got err=%b busy=%b required 0 0", err_o, busy_o);
        end
    endtask

    task automatic test_zero_len();
        load_key(8'h5A);
        start_frame(16'd0);
        checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || out_valid_o !== 1'b0 || err_o !== 1'b0) begin
            failures++;
            $display("FAIL zero_len got done=%b busy=%b ov=%b err=%b required 1 0 0 0",
                     done_o, busy_o, out_valid_o, err_o);
        end
        tick();
        checks++;
        if (done_o !== 1'b0 || out_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL zero_len_after got done=%b ov=%b required 0 0", done_o, out_valid_o);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        out_ready_i = 1'b1;
        start_frame(16'd4);
        checks++;
        if (busy_o !== 1'b1 || in_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL b2b_start got busy=%b ir=%b required 1 1", busy_o, in_ready_o);
        end
        stream_frame(8'h5A, 4, 0, -1, cyc);
        checks++;
        if (cyc != 5) begin
            failures++;
            $display("FAIL b2b_throughput cycles=%0d required 5", cyc);
        end
    endtask

    task automatic test_stall();
        int cyc;
        start_frame(16'd4);
        stream_frame(8'h5A, 4, 1, -1, cyc);
    endtask

    task automatic test_abort();
        int cyc;
        out_ready_i = 1'b1;
        start_frame(16'd5);
        in_valid_i = 1'b1;
        in_data_i  = 8'h11;
        tick();
        in_data_i = 8'h22;
        tick();
        in_valid_i = 1'b0;
        abort_i    = 1'b1;
        tick();
        abort_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || out_valid_o !== 1'b0 || out_last_o !== 1'b0 || done_o !== 1'b0 ||
            in_ready_o !== 1'b0 || err_o !== 1'b0) begin
            failures++;
            $display("FAIL abort_state busy=%b ov=%b ol=%b done=%b ir=%b err=%b required all 0",
                     busy_o, out_valid_o, out_last_o, done_o, in_ready_o, err_o);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (done_o !== 1'b0 || busy_o !== 1'b0) begin
                failures++;
                $display("FAIL abort_quiet k=%0d done=%b busy=%b required 0 0", k, done_o, busy_o);
            end
        end
        start_frame(16'd1);
        stream_frame(8'h5A, 1, 0, -1, cyc);
    endtask

    task automatic test_key_ignore();
        int cyc;
        start_frame(16'd3);
        stream_frame(8'h5A, 3, 0, 1, cyc);
        start_frame(16'd2);
        stream_frame(8'h5A, 2, 0, -1, cyc);
        // key_load and start together: the new key applies to this frame
        key_load_i  = 1'b1;
        key_in_i    = 8'h33;
        start_i     = 1'b1;
        frame_len_i = 16'd3;
        tick();
        key_load_i = 1'b0;
        start_i    = 1'b0;
        checks++;
        if (busy_o !== 1'b1 || err_o !== 1'b0) begin
            failures++;
            $display("FAIL key_same_cycle got busy=%b err=%b required 1 0", busy_o, err_o);
        end
        stream_frame(8'h33, 3, 1, -1, cyc);
    endtask

    task automatic test_reset_mid_frame();
        out_ready_i = 1'b1;
        start_frame(16'd5);
        in_valid_i = 1'b1;
        in_data_i  = 8'h77;
        tick();
        in_valid_i = 1'b0;
        rst_ni     = 1'b0;
        tick();
        rst_ni = 1'b1;
        checks++;
        if (busy_o !== 1'b0 || out_valid_o !== 1'b0 || out_data_o !== 8'h00) begin
            failures++;
            $display("FAIL rst_mid got busy=%b ov=%b od=%h required 0 0 00",
                     busy_o, out_valid_o, out_data_o);
        end
        start_frame(16'd2);
        checks++;
        if (err_o !== 1'b1 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL rst_key_clear got err=%b busy=%b required 1 0", err_o, busy_o);
        end
    endtask

    task automatic test_max_frame();
        int cyc;
        load_key(8'hC3);
        start_frame(16'hFFFF);
        stream_frame(8'hC3, 65535, 2, -1, cyc);
    endtask

    initial begin
        test_reset();
        test_err_no_key();
        test_zero_len();
        test_back_to_back();
        test_stall();
        test_abort();
        test_key_ignore();
        test_reset_mid_frame();
        test_max_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decrypt_stream_ctrl.md
# decrypt_stream_ctrl

Frame-level controller that sequences the byte-wide `decrypt` datapath on the decompression path. It holds the 8-bit key and accepts a frame length on a start pulse. It then streams exactly that many encrypted bytes through `decrypt` with valid/ready handshakes on both sides, flags the last byte, and reports completion. It sits between the bitstream byte source and the Huffman decoder input.

## Interface
- `LEN_W`, 16, width of frame length and byte counter; max frame = 2^LEN_W−1 bytes
- `clk`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `key_load`  in  1  pulse; latch `key_in` (honoured only in IDLE)
- `key_in`  in  8  decryption key
- `start`  in  1  pulse; begin frame (honoured only in IDLE)
- `frame_len`  in  LEN_W  byte count of frame, sampled with `start`
- `abort`  in  1  synchronous frame cancel
- `in_valid`  in  1  encrypted byte available
- `in_data`  in  8  encrypted byte
- `in_ready`  out  1  controller accepts `in_data` this cycle
- `out_valid`  out  1  decrypted byte available
- `out_data`  out  8  decrypted byte
- `out_last`  out  1  qualifies final byte of frame (valid only with `out_valid`)
- `out_ready`  in  1  downstream accepts `out_data`
- `busy`  out  1  state ≠ IDLE
- `done`  out  1  one-cycle pulse, frame completed
- `err`  out  1  one-cycle pulse, `start` rejected (no key loaded)

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE:
  - `key_load` → `key_reg`←`key_in`, `key_vld`←1.
  - `start` with `key_vld`=0 → `err` pulse, stay IDLE.
  - `start`, `frame_len`=0 → `done` pulse, stay IDLE.
  - Otherwise latch `len_reg`, clear `cnt`, go RUN.
  - If `key_load` and `start` occur in the same cycle, the key is loaded first and `start` uses the new key.
- RUN:
  - `in_ready` = !`out_valid` || `out_ready`.
  - On accept (`in_valid`&&`in_ready`):
    - output register ← `decrypt`(`in_data`, `key_reg`) = ~(`in_data`^`key_reg`)
    - `out_valid`←1
    - `out_last`←(`cnt`==`len_reg`−1)
    - `cnt`++
  - Accepting the last byte → DRAIN.
  - `out_ready` without a new accept clears `out_valid`.
- DRAIN:
  - `in_ready`=0.
  - When `out_valid`&&`out_ready` (last byte leaves): `out_valid`←0, `done` pulse, go IDLE.
- `key_load`/`start` outside IDLE: ignored, no error.
- `abort` (any state, priority over all else):
  - next cycle state=IDLE, `out_valid`=0, `out_last`=0, `cnt`=0
  - no `done`, no `err`
  - key and `key_vld` retained
- `out_data`/`out_last` hold stable while `out_valid`&&!`out_ready`.
- Counter arithmetic is unsigned LEN_W bits. `len_reg`−1 never underflows because len 0 never enters RUN.

## Timing
- Reset values:
  - `in_ready`=0, `out_valid`=0, `out_data`=0, `out_last`=0
  - `busy`=0, `done`=0, `err`=0
  - `key_reg`=0, `key_vld`=0, state=IDLE
- `start` at cycle T → `busy`=1 and `in_ready` may be 1 at T+1.
- Latency: byte accepted at cycle T → `out_valid` at T+1.
- Throughput: 1 byte/cycle with `out_ready` held high.
- Last byte consumed downstream at cycle T → `done`=1 at T+1 and `busy`=0 at T+1; a new `start` is accepted at T+1.
- `err` and zero-length `done` assert in the cycle after `start`.
- Reset mid-frame behaves as `abort` plus key clear.

## Structure
- Shared package `decomp_pkg`:
  - state enum (IDLE/RUN/DRAIN)
  - `BYTE_W`=8 constant
  - `KEY_W`=8 constant
- Sub-module: one instance of the existing `decrypt` core, driven by `in_data` and `key_reg`, combinational into the output register.
- FSM, counter, key register and output register live in this block.

## Test plan
- Load key 0x5A, start len=4, send 0x00,0xFF,0xA5,0x5A back-to-back with `out_ready`=1 → out 0xA5,0x5A,0x00,0xFF on consecutive cycles, `out_last` on 4th only, `done` one cycle after the 4th output.
- Same frame with `out_ready` toggling 1,0,0,1,… → no byte lost or duplicated, `out_data` stable while stalled, `in_ready` low whenever the output is held.
- `start` after reset with no key → `err` pulse, `busy` stays 0; `start` with `frame_len`=0 after key load → `done` pulse, no output.
- `abort` after 2 of 5 bytes → IDLE next cycle, `out_valid`=0, no `done`; a following `start` len=1 with the retained key decrypts correctly.
- `key_load` 0x33 during RUN → ignored, frame continues with the old key; after `done`, a new frame uses 0x33 only if reloaded in IDLE.
- Max `frame_len`=0xFFFF with random stalls → exactly 65535 outputs, `out_last` only on the final byte.
